// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, protocol nibble codes, record layout
// and the nibble shift-register helper used by the cycle decoder.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_CYCTYPE, ST_ADDR, ST_WDATA,
    ST_TAR1, ST_SYNC, ST_RDATA, ST_TAR2
  } lpc_state_e;

  localparam logic [3:0] START_CODE = 4'b0000;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [1:0] CT_IO      = 2'b00;
  localparam logic [1:0] CT_MEM     = 2'b01;
  localparam int         CT_DIR_BIT = 1;

  localparam int REC_CT_LSB   = 44;
  localparam int REC_FLAG_LSB = 40;
  localparam int REC_ADDR_LSB = 8;
  localparam int REC_DATA_LSB = 0;
  localparam int FLAG_SYNC_ERR = 0;
  localparam int FLAG_WAIT     = 1;

  // MSB-first nibble shift register step
  function automatic logic [31:0] nib_shift_in(input logic [31:0] sr, input logic [3:0] nib);
    return {sr[27:0], nib};
  endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// LPC I/O (and optionally memory) cycle decoder emitting 48-bit records.
// Define LPC_MEM_CYCLES_EN to record memory cycles with a 32-bit address.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lframe_n,
  input  logic [3:0]  lad,
  output logic [47:0] out_data,
  output logic        out_clock_enable,
  output logic        busy
);

`ifdef LPC_MEM_CYCLES_EN
  localparam int AW = 32;
`else
  localparam int AW = 16;
`endif
  localparam int WCW = (SYNC_TIMEOUT < 2) ? 1 : $clog2(SYNC_TIMEOUT + 1);

  lpc_state_e      r_state, w_state;
  logic [3:0]      r_ct, w_ct;
  logic [2:0]      r_cnt, w_cnt;
  logic [AW-1:0]   r_addr, w_addr;
  logic [7:0]      r_data, w_data;
  logic            r_wait, w_wait;
  logic            r_err, w_err;
  logic [WCW-1:0]  r_wcnt, w_wcnt;
  logic [47:0]     r_out, w_rec;
  logic            r_stb, w_stb;
  logic            w_is_mem, w_rec_ok;
  logic [2:0]      w_last_nib;

  assign w_is_mem   = (r_ct[3:2] == CT_MEM);
  assign w_last_nib = w_is_mem ? 3'd7 : 3'd3;
`ifdef LPC_MEM_CYCLES_EN
  assign w_rec_ok = 1'b1;
`else
  // Memory cycles are still walked through every phase so the FSM stays in
  // step with the bus; they just never produce a record.
  assign w_rec_ok = !w_is_mem;
`endif

  always_comb begin
    w_state = r_state;
    w_ct    = r_ct;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_data  = r_data;
    w_wait  = r_wait;
    w_err   = r_err;
    w_wcnt  = r_wcnt;
    w_stb   = 1'b0;
    if (!lframe_n) begin
      // Any LFRAME# low is a (re)start: aborts whatever was in flight.
      w_state = (lad == START_CODE) ? ST_START : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state = ST_IDLE;
        ST_START: begin
          w_ct    = lad;
          w_addr  = '0;
          w_data  = '0;
          w_wait  = 1'b0;
          w_err   = 1'b0;
          w_wcnt  = '0;
          w_cnt   = '0;
          w_state = ST_CYCTYPE;
        end
        ST_CYCTYPE: begin
          if (r_ct[3:2] == CT_IO || r_ct[3:2] == CT_MEM) begin
            w_addr  = AW'(nib_shift_in(32'(r_addr), lad));
            w_cnt   = 3'd1;
            w_state = ST_ADDR;
          end else begin
            w_state = ST_IDLE;
          end
        end
        ST_ADDR: begin
          w_addr = AW'(nib_shift_in(32'(r_addr), lad));
          if (r_cnt == w_last_nib) begin
            w_cnt   = '0;
            w_state = r_ct[CT_DIR_BIT] ? ST_WDATA : ST_TAR1;
          end else begin
            w_cnt = r_cnt + 3'd1;
          end
        end
        ST_WDATA: begin
          w_data = {lad, r_data[7:4]};
          w_cnt  = (r_cnt == 3'd1) ? 3'd0 : 3'd1;
          if (r_cnt == 3'd1) w_state = ST_TAR1;
        end
        ST_TAR1: begin
          w_cnt = (r_cnt == 3'd1) ? 3'd0 : 3'd1;
          if (r_cnt == 3'd1) w_state = ST_SYNC;
        end
        ST_SYNC: begin
          case (lad)
            SYNC_READY: begin
              if (r_ct[CT_DIR_BIT]) begin
                w_state = ST_TAR2;
                w_stb   = w_rec_ok;
              end else begin
                w_state = ST_RDATA;
              end
            end
            SYNC_SWAIT, SYNC_LWAIT: begin
              w_wait = 1'b1;
              if (r_wcnt == WCW'(SYNC_TIMEOUT - 1)) w_state = ST_IDLE;
              else                                  w_wcnt  = r_wcnt + 1'b1;
            end
            SYNC_ERR: begin
              w_err   = 1'b1;
              w_data  = '0;
              w_state = ST_TAR2;
              w_stb   = w_rec_ok;
            end
            default: w_state = ST_IDLE;
          endcase
        end
        ST_RDATA: begin
          w_data = {lad, r_data[7:4]};
          w_cnt  = (r_cnt == 3'd1) ? 3'd0 : 3'd1;
          if (r_cnt == 3'd1) begin
            w_state = ST_TAR2;
            w_stb   = w_rec_ok;
          end
        end
        ST_TAR2: begin
          w_cnt = (r_cnt == 3'd1) ? 3'd0 : 3'd1;
          if (r_cnt == 3'd1) w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rec = '0;
    w_rec[REC_CT_LSB +: 4]               = r_ct;
    w_rec[REC_FLAG_LSB + FLAG_WAIT]      = w_wait;
    w_rec[REC_FLAG_LSB + FLAG_SYNC_ERR]  = w_err;
    w_rec[REC_ADDR_LSB +: 32]            = 32'(w_addr);
    w_rec[REC_DATA_LSB +: 8]             = w_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ct    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wait  <= 1'b0;
      r_err   <= 1'b0;
      r_wcnt  <= '0;
      r_out   <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ct    <= w_ct;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_wait  <= w_wait;
      r_err   <= w_err;
      r_wcnt  <= w_wcnt;
      r_stb   <= w_stb;
      if (w_stb) r_out <= w_rec;
    end
  end

  assign out_data         = r_out;
  assign out_clock_enable = r_stb;
  assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder (SYNC_TIMEOUT=4 instance).
module tb_lpc_cycle_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lframe_n = 1'b1;
  logic [3:0]  lad = 4'hF;
  logic [47:0] out_data;
  logic        out_clock_enable;
  logic        busy;

  int          n_chk = 0;
  int          n_fail = 0;
  int          nstb = 0;
  int          s0;
  logic [47:0] cap = '0;
  logic [47:0] exp_mem;
  int          exp_mem_n;

  lpc_cycle_decoder #(.SYNC_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .lframe_n(lframe_n), .lad(lad),
    .out_data(out_data), .out_clock_enable(out_clock_enable), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one bus clock: drive, clock, then sample just after the edge
  task automatic nib(input logic lf, input logic [3:0] v);
    lframe_n = lf;
    lad      = v;
    @(posedge clock);
    #1;
    if (out_clock_enable) begin
      nstb++;
      cap = out_data;
    end
  endtask

  task automatic xfer(input logic [3:0] ct, input logic [31:0] addr, input int nn,
                      input logic [7:0] d, input int nwait, input logic [3:0] sync);
    nib(1'b0, 4'h0);
    nib(1'b1, ct);
    for (int i = nn - 1; i >= 0; i--) nib(1'b1, addr[i*4 +: 4]);
    if (ct[1]) begin
      nib(1'b1, d[3:0]);
      nib(1'b1, d[7:4]);
    end
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    for (int i = 0; i < nwait; i++) nib(1'b1, 4'h6);
    nib(1'b1, sync);
    if (!ct[1] && sync == 4'h0) begin
      nib(1'b1, d[3:0]);
      nib(1'b1, d[7:4]);
    end
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
  endtask

  initial begin
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    check("reset_data", out_data, 48'h0);
    check("reset_stb", {47'h0, out_clock_enable}, 48'h0);
    check("reset_busy", {47'h0, busy}, 48'h0);
    reset = 1'b0;
    nib(1'b1, 4'hF);

    // I/O write 0x0080 <- 0x5A
    s0 = nstb;
    xfer(4'h2, 32'h0080, 4, 8'h5A, 0, 4'h0);
    check("iow_count", 48'(nstb - s0), 48'd1);
    check("iow_data", cap, 48'h20_0000_0080_5A);
    check("iow_busy_end", {47'h0, busy}, 48'h0);
    nib(1'b1, 4'hF);
    check("iow_hold", out_data, 48'h20_0000_0080_5A);

    // I/O read 0x0060, two long waits, data 0xFA
    s0 = nstb;
    xfer(4'h0, 32'h0060, 4, 8'hFA, 2, 4'h0);
    check("ior_wait_count", 48'(nstb - s0), 48'd1);
    check("ior_wait_data", cap, 48'h02_0000_0060_FA);

    // abort during third address nibble, restart as write 0x0081 <- 0x11
    s0 = nstb;
    nib(1'b0, 4'h0);
    nib(1'b1, 4'h2);
    check("abort_busy", {47'h0, busy}, 48'h1);
    nib(1'b1, 4'h0);
    nib(1'b1, 4'h0);
    nib(1'b0, 4'h0);
    xfer(4'h2, 32'h0081, 4, 8'h11, 0, 4'h0);
    check("abort_count", 48'(nstb - s0), 48'd1);
    check("abort_data", cap, 48'h20_0000_0081_11);

    // I/O read 0x0064 with SYNC error
    s0 = nstb;
    xfer(4'h0, 32'h0064, 4, 8'h33, 0, 4'hA);
    check("serr_count", 48'(nstb - s0), 48'd1);
    check("serr_data", cap, 48'h01_0000_0064_00);

    // memory read 0xFFFFFFF0 -> 0x90
`ifdef LPC_MEM_CYCLES_EN
    exp_mem   = 48'h40_FFFF_FFF0_90;
    exp_mem_n = 1;
`else
    exp_mem   = 48'h01_0000_0064_00;
    exp_mem_n = 0;
`endif
    s0 = nstb;
    xfer(4'h4, 32'hFFFF_FFF0, 8, 8'h90, 0, 4'h0);
    check("mem_count", 48'(nstb - s0), 48'(exp_mem_n));
    check("mem_data", out_data, exp_mem);
    check("mem_busy_end", {47'h0, busy}, 48'h0);

    // five long waits against a limit of four
    s0 = nstb;
    nib(1'b0, 4'h0);
    nib(1'b1, 4'h0);
    for (int i = 3; i >= 0; i--) nib(1'b1, 4'(i));
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    for (int i = 0; i < 3; i++) nib(1'b1, 4'h6);
    check("tmo_busy_mid", {47'h0, busy}, 48'h1);
    nib(1'b1, 4'h6);
    check("tmo_busy_idle", {47'h0, busy}, 48'h0);
    nib(1'b1, 4'h6);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    check("tmo_count", 48'(nstb - s0), 48'd0);

    // invalid start code, then the rest of a write: no record
    s0 = nstb;
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h3);
    check("badstart_busy", {47'h0, busy}, 48'h0);
    nib(1'b1, 4'h2);
    for (int i = 0; i < 9; i++) nib(1'b1, 4'h0);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'hF);
    check("badstart_count", 48'(nstb - s0), 48'd0);

    // back-to-back writes
    s0 = nstb;
    xfer(4'h2, 32'h1234, 4, 8'hC3, 0, 4'h0);
    xfer(4'h2, 32'hABCD, 4, 8'h7E, 1, 4'h0);
    check("b2b_count", 48'(nstb - s0), 48'd2);
    check("b2b_data", cap, 48'h22_0000_ABCD_7E);

    // reset mid-address
    s0 = nstb;
    nib(1'b0, 4'h0);
    nib(1'b1, 4'h2);
    nib(1'b1, 4'h5);
    nib(1'b1, 4'h5);
    reset = 1'b1;
    nib(1'b1, 4'h5);
    check("rst_mid_data", out_data, 48'h0);
    check("rst_mid_busy", {47'h0, busy}, 48'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) nib(1'b1, 4'h0);
    check("rst_mid_count", 48'(nstb - s0), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_cycle_decoder.md
LPC_CYCLE_DECODER -- requirements
Module: lpc_cycle_decoder

Interface
REQ-001 SHALL provide parameter SYNC_TIMEOUT, default 255: maximum consecutive wait-SYNC nibbles (0101/0110) tolerated before the cycle is abandoned.
REQ-002 SHALL have port clock  input  1  the LPC clock, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port lframe_n  input  1  LPC LFRAME#, active low.
REQ-005 SHALL have port lad  input  4  LPC LAD[3:0] nibble bus.
REQ-006 SHALL have port out_data  output  48  decoded cycle record, written to the ring buffer write_data.
REQ-007 SHALL have port out_clock_enable  output  1  one-cycle strobe marking out_data valid; drives the ring buffer write_clock_enable.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is outside IDLE.

Function
REQ-009 SHALL pack records as: [47:44] CYCTYPE/DIR nibble; [43:40] flags; [39:8] address, zero-extended; [7:0] data.
REQ-010 SHALL use flags bit40 = SYNC error (1010), bit41 = at least one wait SYNC seen, and bits 43:42 = 0.
REQ-011 SHALL implement states IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, and TAR2.
REQ-012 IDLE->START SHALL occur when lframe_n=0 and lad=0000; START SHALL hold while lframe_n=0, and the last nibble sampled with lframe_n=0 is the start code.
REQ-013 A start code other than 0000 SHALL return the FSM to IDLE with no record.
REQ-014 In CYCTYPE, on the first cycle with lframe_n=1, the FSM SHALL latch lad: [3:2]=00 selects I/O (4 address nibbles), 01 selects memory (8 nibbles), any other value returns to IDLE; lad[1]=1 selects write.
REQ-015 Address nibbles SHALL be received MSB first; data nibbles SHALL be received low nibble first.
REQ-016 The write sequence SHALL be ADDR->WDATA(2)->TAR1(2)->SYNC->TAR2(2); the read sequence SHALL be ADDR->TAR1(2)->SYNC->RDATA(2)->TAR2(2).
REQ-017 In SYNC, 0000 SHALL proceed; 0101 or 0110 SHALL stay, set flag bit41, and increment the wait counter; 1010 SHALL set bit40, force data to 0x00, and go to TAR2; any other nibble SHALL return to IDLE with no record.
REQ-018 out_clock_enable SHALL pulse for exactly one clock on the first TAR2 cycle, with out_data stable from that cycle until the next strobe.
REQ-019 A wait counter reaching SYNC_TIMEOUT with no ready SYNC SHALL send the FSM to IDLE with no record.
REQ-020 lframe_n=0 in any state other than IDLE or START SHALL abort the current cycle (no record) and SHALL be evaluated as a new START on the same edge.
REQ-021 TAR2 SHALL last 2 cycles and then return to IDLE; back-to-back cycles SHALL be decoded with no dead cycles.

Reset
REQ-022 reset SHALL force state IDLE, out_clock_enable=0, out_data=0, busy=0, and clear the wait counter and all shift registers.
REQ-023 reset asserted mid-cycle SHALL discard the partial cycle and SHALL NOT emit a strobe on or after that edge.

Configuration
REQ-024 With macro LPC_MEM_CYCLES_EN defined, memory cycles SHALL be decoded and recorded like I/O cycles.
REQ-025 Without LPC_MEM_CYCLES_EN, memory cycles SHALL still be tracked through all states to stay in protocol sync, but SHALL NOT generate a strobe, and the 32-bit address logic SHALL be reduced to 16 bits.

Structure
REQ-026 A shared package lpc_pkg SHALL hold the FSM state enum, the SYNC code constants (0000, 0101, 0110, 1010), the CYCTYPE field constants, and the record field offsets.
REQ-027 The design SHALL be a single module; a nibble shift register SHALL be the only reusable fragment, with no sub-module required.

Verification
REQ-028 I/O write to 0x0080 with data 0x5A and SYNC 0000 -> one strobe, out_data=48'h20_0000_0080_5A.
REQ-029 I/O read of 0x0060 with two 0110 SYNCs, then 0000, then data 0xFA -> out_data=48'h02_0000_0060_FA.
REQ-030 lframe_n pulled low during the third address nibble, followed by a valid I/O write to 0x0081 with data 0x11 -> exactly one strobe, for the 0x0081 cycle.
REQ-031 I/O read of 0x0064 with SYNC 1010 -> out_data=48'h01_0000_0064_00.
REQ-032 Memory read of 0xFFFFFFF0 with data 0x90 -> with LPC_MEM_CYCLES_EN: out_data=48'h40_FFFF_FFF0_90; without it: no strobe, and busy returns low after TAR2.
REQ-033 SYNC_TIMEOUT=4 and five 0110 SYNCs -> no strobe, busy=0; reset asserted mid-ADDR -> no strobe and outputs zero on the next edge.
